// File: rtl/fir_pkg.sv
// Shared widths and FSM state encoding for the time-multiplexed FIR sequencer.
package fir_pkg;
    localparam int DW        = 16;
    localparam int AW        = 39;
    localparam int NTAPS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_t;
endpackage

// File: rtl/fir_coef_bank.sv
// NTAPS x DW coefficient register file: gated write port, combinational read.
module fir_coef_bank #(
    parameter int NTAPS = 8,
    parameter int DW    = 16,
    parameter int CAW   = $clog2(NTAPS)
) (
    input  logic           clk,
    input  logic           R_n,
    input  logic           we,
    input  logic [CAW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [CAW-1:0] raddr,
    output logic [DW-1:0]  rdata
);
    logic [DW-1:0] mem [NTAPS];
    logic          addr_ok;

    // Addresses past the last tap are dropped rather than aliased.
    assign addr_ok = {1'b0, waddr} < (CAW+1)'(NTAPS);

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            for (int k = 0; k < NTAPS; k++) mem[k] <= '0;
        end else if (we && addr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fir_mac_sequencer.sv
// Streams NTAPS (sample, coef) pairs per input sample into an external MAC and captures the sum.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = fir_pkg::NTAPS_DEF,
    parameter int DW    = fir_pkg::DW,
    parameter int AW    = fir_pkg::AW,
    parameter int CAW   = $clog2(NTAPS)
) (
    input  logic           clk,
    input  logic           R_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_sample,
    input  logic           coef_we,
    input  logic [CAW-1:0] coef_addr,
    input  logic [DW-1:0]  coef_wdata,
    output logic [DW-1:0]  mac_X,
    output logic [DW-1:0]  mac_B,
    output logic           mac_R,
    input  logic [AW-1:0]  mac_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  out_data
);
    if (NTAPS < 2 || NTAPS > 128 || AW < 2*DW + CAW) begin : g_bad_cfg
        $error("fir_mac_sequencer: NTAPS must be 2..128 and AW wide enough for an overflow-free sum");
    end

    state_t         state, state_nxt;
    logic [CAW-1:0] idx;
    logic [DW-1:0]  delay [NTAPS];
    logic [DW-1:0]  coef_rd;
    logic           coef_we_idle;
    logic           last_tap;

    assign coef_we_idle = coef_we && (state == IDLE);
    assign last_tap     = (idx == CAW'(NTAPS-1));

    fir_coef_bank #(.NTAPS(NTAPS), .DW(DW), .CAW(CAW)) u_coef (
        .clk   (clk),
        .R_n   (R_n),
        .we    (coef_we_idle),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .raddr (idx),
        .rdata (coef_rd)
    );

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) state <= IDLE;
        else      state <= state_nxt;
    end

    // mac_R stays asserted outside MAC/DRAIN so every sample starts from a clean accumulator.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mac_R     = 1'b1;
        mac_X     = '0;
        mac_B     = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MAC;
            end
            MAC: begin
                mac_R = 1'b0;
                mac_X = delay[idx];
                mac_B = coef_rd;
                if (last_tap) state_nxt = DRAIN;
            end
            DRAIN: begin
                mac_R     = 1'b0;
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            idx      <= '0;
            out_data <= '0;
            for (int k = 0; k < NTAPS; k++) delay[k] <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    idx      <= '0;
                    delay[0] <= in_sample;
                    for (int k = 1; k < NTAPS; k++) delay[k] <= delay[k-1];
                end
                MAC:     idx      <= idx + CAW'(1);
                DRAIN:   out_data <= mac_y;
                default: ;
            endcase
        end
    end
endmodule
